rubik_move_sequencer: RTL and testbench

RUBIK_MOVE_SEQUENCER -- requirements
Module: rubik_move_sequencer

---
 rtl/rubik_move_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rubik_move_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rubik_move_sequencer.sv
// rtl/rubik_move_sequencer.sv - UART byte decoder and four-servo face-move sequencer
// One pending move slot feeds a ROT/OPEN/HOME/CLOSE dwell FSM per face turn.
module rubik_move_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2000000
) (
  input  logic       I_sys_clk,
  input  logic       I_on_board_reset,
  input  logic [7:0] I_rx_data,
  input  logic       I_rx_valid,
  output logic [7:0] o_servo_dir_pos,
  output logic [3:0] o_servo_grip,
  output logic       o_scan_start,
  output logic       o_busy,
  output logic       o_move_done,
  output logic       o_cmd_error,
  output logic       o_overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROT   = 3'd1,
    OPEN  = 3'd2,
    HOME  = 3'd3,
    CLOSE = 3'd4
  } state_t;

  localparam logic [23:0] DWELL_LAST = 24'(SETTLE_CYCLES - 1);

  localparam logic [1:0] POS_NEG  = 2'd0;
  localparam logic [1:0] POS_HOME = 2'd1;
  localparam logic [1:0] POS_POS  = 2'd2;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        pend_valid_q, pend_valid_d;
  logic [2:0]  pend_code_q, pend_code_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  dir_q, dir_d;
  logic [3:0]  grip_q, grip_d;
  logic        scan_q, scan_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  // Byte decode: move code is {servo index, clockwise}
  logic       is_move;
  logic       is_scan;
  logic       is_err;
  logic [2:0] move_code;

  always_comb begin
    is_move   = 1'b0;
    is_scan   = 1'b0;
    is_err    = 1'b0;
    move_code = 3'd0;
    case (I_rx_data)
      8'h61: begin is_move = 1'b1; move_code = {2'd0, 1'b1}; end
      8'h63: begin is_move = 1'b1; move_code = {2'd1, 1'b1}; end
      8'h64: begin is_move = 1'b1; move_code = {2'd2, 1'b1}; end
      8'h65: begin is_move = 1'b1; move_code = {2'd3, 1'b1}; end
      8'h41: begin is_move = 1'b1; move_code = {2'd0, 1'b0}; end
      8'h43: begin is_move = 1'b1; move_code = {2'd1, 1'b0}; end
      8'h44: begin is_move = 1'b1; move_code = {2'd2, 1'b0}; end
      8'h45: begin is_move = 1'b1; move_code = {2'd3, 1'b0}; end
      8'h62: is_scan = 1'b1;
      default: is_err = 1'b1;
    endcase
  end

  logic consume;
  logic dwell_done;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 24'd1;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    sel_d        = sel_q;
    dir_d        = dir_q;
    grip_d       = grip_q;
    scan_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    ovf_d        = 1'b0;

    consume    = (state_q == IDLE) && pend_valid_q;
    dwell_done = (timer_q == DWELL_LAST);

    case (state_q)
      IDLE: begin
        timer_d = 24'd0;
        if (consume) begin
          state_d = ROT;
          sel_d   = pend_code_q[2:1];
          dir_d[{pend_code_q[2:1], 1'b0} +: 2] = pend_code_q[0] ? POS_POS : POS_NEG;
        end
      end
      ROT: begin
        if (dwell_done) begin
          state_d       = OPEN;
          timer_d       = 24'd0;
          grip_d[sel_q] = 1'b0;
        end
      end
      OPEN: begin
        if (dwell_done) begin
          state_d = HOME;
          timer_d = 24'd0;
          dir_d[{sel_q, 1'b0} +: 2] = POS_HOME;
        end
      end
      HOME: begin
        if (dwell_done) begin
          state_d       = CLOSE;
          timer_d       = 24'd0;
          grip_d[sel_q] = 1'b1;
        end
      end
      CLOSE: begin
        if (dwell_done) begin
          state_d = IDLE;
          timer_d = 24'd0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 24'd0;
      end
    endcase

    // A slot being drained this cycle can be refilled in the same cycle
    if (consume) pend_valid_d = 1'b0;
    if (I_rx_valid) begin
      scan_d = is_scan;
      err_d  = is_err;
      if (is_move) begin
        if (!pend_valid_q || consume) begin
          pend_valid_d = 1'b1;
          pend_code_d  = move_code;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_on_board_reset) begin
    if (I_on_board_reset) begin
      state_q      <= IDLE;
      timer_q      <= 24'd0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 3'd0;
      sel_q        <= 2'd0;
      dir_q        <= 8'h55;
      grip_q       <= 4'hF;
      scan_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      grip_q       <= grip_d;
      scan_q       <= scan_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_servo_dir_pos = dir_q;
  assign o_servo_grip    = grip_q;
  assign o_scan_start    = scan_q;
  assign o_busy          = (state_q != IDLE);
  assign o_move_done     = done_q;
  assign o_cmd_error     = err_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_rubik_move_sequencer.sv
// tb/tb_rubik_move_sequencer.sv - directed self-checking bench for rubik_move_sequencer
module tb_rubik_move_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] dir;
  logic [3:0] grip;
  logic       scan_start;
  logic       busy;
  logic       move_done;
  logic       cmd_error;
  logic       overflow;

  int vectors;
  int miscompares;
  int done_seen;

  rubik_move_sequencer #(.SETTLE_CYCLES(4)) dut (
    .I_sys_clk        (clk),
    .I_on_board_reset (rst),
    .I_rx_data        (rx_data),
    .I_rx_valid       (rx_valid),
    .o_servo_dir_pos  (dir),
    .o_servo_grip     (grip),
    .o_scan_start     (scan_start),
    .o_busy           (busy),
    .o_move_done      (move_done),
    .o_cmd_error      (cmd_error),
    .o_overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    #2;
    chk("rst_dir", 32'(dir), 32'h55);
    chk("rst_grip", 32'(grip), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({scan_start, move_done, cmd_error, overflow}), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // scan start
    send(8'h62);
    chk("scan_pulse", 32'(scan_start), 32'd1);
    chk("scan_busy", 32'(busy), 32'd0);
    chk("scan_dir", 32'(dir), 32'h55);
    chk("scan_grip", 32'(grip), 32'hF);
    tick(1);
    chk("scan_one_cycle", 32'(scan_start), 32'd0);

    // left clockwise
    send(8'h61);
    chk("cw_n_dir", 32'(dir), 32'h55);
    tick(1);
    chk("cw_n1_dir", 32'(dir), 32'h56);
    chk("cw_n1_busy", 32'(busy), 32'd1);
    tick(4);
    chk("cw_n5_grip", 32'(grip), 32'hE);
    tick(4);
    chk("cw_n9_dir", 32'(dir), 32'h55);
    tick(4);
    chk("cw_n13_grip", 32'(grip), 32'hF);
    tick(3);
    chk("cw_n16_done", 32'(move_done), 32'd0);
    chk("cw_n16_busy", 32'(busy), 32'd1);
    tick(1);
    chk("cw_n17_done", 32'(move_done), 32'd1);
    chk("cw_n17_busy", 32'(busy), 32'd0);
    tick(1);
    chk("cw_done_one_cycle", 32'(move_done), 32'd0);

    // left counter-clockwise
    send(8'h41);
    tick(1);
    chk("ccw_n1_dir", 32'(dir), 32'h54);
    tick(4);
    chk("ccw_n5_grip", 32'(grip), 32'hE);
    tick(4);
    chk("ccw_n9_dir", 32'(dir), 32'h55);
    tick(4);
    chk("ccw_n13_grip", 32'(grip), 32'hF);
    tick(4);
    chk("ccw_n17_done", 32'(move_done), 32'd1);

    // invalid byte
    tick(2);
    send(8'h7A);
    chk("err_pulse", 32'(cmd_error), 32'd1);
    chk("err_others", 32'({scan_start, move_done, overflow, busy}), 32'd0);
    chk("err_dir", 32'(dir), 32'h55);
    chk("err_grip", 32'(grip), 32'hF);
    tick(1);
    chk("err_one_cycle", 32'(cmd_error), 32'd0);
    chk("err_no_move", 32'(busy), 32'd0);

    // buffering, overflow, refill on consume
    send(8'h61);
    tick(1);
    send(8'h63);
    chk("buf_accept_ovf", 32'(overflow), 32'd0);
    tick(3);
    send(8'h64);
    chk("buf_drop_ovf", 32'(overflow), 32'd1);
    tick(1);
    chk("buf_ovf_one_cycle", 32'(overflow), 32'd0);
    tick(10);
    chk("buf_n17_done", 32'(move_done), 32'd1);
    chk("buf_n17_dir", 32'(dir), 32'h55);
    chk("buf_n17_busy", 32'(busy), 32'd0);
    send(8'h64);
    chk("buf_n18_dir", 32'(dir), 32'h59);
    chk("buf_n18_busy", 32'(busy), 32'd1);
    chk("buf_refill_ovf", 32'(overflow), 32'd0);
    tick(4);
    chk("buf_n22_grip", 32'(grip), 32'hD);
    tick(12);
    chk("buf_n34_done", 32'(move_done), 32'd1);
    tick(1);
    chk("buf_n35_dir", 32'(dir), 32'h65);
    tick(16);
    chk("buf_n51_done", 32'(move_done), 32'd1);
    chk("buf_n51_dir", 32'(dir), 32'h55);
    chk("buf_n51_grip", 32'(grip), 32'hF);
    tick(2);

    // reset during OPEN
    send(8'h61);
    tick(5);
    chk("rstmid_grip_open", 32'(grip), 32'hE);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_dir", 32'(dir), 32'h55);
    chk("rstmid_grip", 32'(grip), 32'hF);
    chk("rstmid_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (move_done) done_seen++;
    end
    chk("rstmid_no_done", 32'(done_seen), 32'd0);
    chk("rstmid_idle", 32'(busy), 32'd0);
    chk("rstmid_dir_after", 32'(dir), 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
